// File: rtl/parity_frame_gen_pkg.sv
// Shared types and helpers for the streaming frame parity generator.
// Also used by the parity checker blocks that reuse parity_tree.
package parity_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Widest word the helper function reduces; narrower words are zero-extended.
    localparam int PAR_FN_W = 1024;

    function automatic logic word_parity(input logic [PAR_FN_W-1:0] data);
        return ^data;
    endfunction

    function automatic int cw_of(input int max_words);
        return $clog2(max_words + 1);
    endfunction

    localparam int CW_DEFAULT = cw_of(16);

endpackage

// File: rtl/parity_frame_gen_if.sv
// Word-in / result-out valid/ready bundle for parity_frame_gen.
// The PARITY_CHECK_EN macro adds in_par and out_err.
interface parity_frame_gen_if
    import parity_pkg::*;
#(
    parameter int WIDTH     = 9,
    parameter int MAX_WORDS = 16
);
    localparam int CW = cw_of(MAX_WORDS);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_ovf;
`ifdef PARITY_CHECK_EN
    logic             in_par;
    logic             out_err;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
`ifdef PARITY_CHECK_EN
        output in_par,
        input  out_err,
`endif
        input  in_ready, out_valid, out_parity, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
`ifdef PARITY_CHECK_EN
        input  in_par,
        output out_err,
`endif
        output in_ready, out_valid, out_parity, out_count, out_ovf
    );

endinterface

// File: rtl/parity_frame_gen_tree.sv
// Combinational XOR reduction of one WIDTH-bit word.
module parity_tree
    import parity_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);
    assign parity_o = word_parity(PAR_FN_W'(data_i));
endmodule

// File: rtl/parity_frame_gen.sv
// Frame parity generator: accumulates parity over a valid/ready word stream and holds one result per frame.
// Optional PARITY_CHECK_EN compares the result against a supplied in_par and reports out_err.
module parity_frame_gen
    import parity_pkg::*;
#(
    parameter int WIDTH     = 9,
    parameter int MAX_WORDS = 16,
    parameter int ODD       = 0
) (
    input logic               clk,
    input logic               rst,
    parity_frame_gen_if.slave bus
);
    localparam int   CW      = cw_of(MAX_WORDS);
    localparam logic ODD_BIT = (ODD != 0);

    state_e        state_q;
    logic          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          word_par;
    logic          accept;
    logic          close;
    logic          out_valid_q;
    logic          out_parity_q;
    logic [CW-1:0] out_count_q;
    logic          out_ovf_q;

    parity_tree #(.WIDTH(WIDTH)) u_tree (
        .data_i   (bus.in_data),
        .parity_o (word_par)
    );

    assign bus.in_ready   = (state_q == ACC);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_parity = out_parity_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_ovf    = out_ovf_q;

    assign accept = bus.in_valid & (state_q == ACC);
    assign acc_d  = acc_q ^ word_par;
    assign cnt_d  = cnt_q + 1'b1;
    // A frame closes on in_last or when this beat would be the MAX_WORDS-th.
    assign close  = bus.in_last | (cnt_q == CW'(MAX_WORDS - 1));

`ifdef PARITY_CHECK_EN
    logic out_err_q;
    assign bus.out_err = out_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACC;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
            out_count_q  <= '0;
            out_ovf_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            out_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        if (close) begin
                            state_q      <= HOLD;
                            out_valid_q  <= 1'b1;
                            out_parity_q <= acc_d ^ ODD_BIT;
                            out_count_q  <= cnt_d;
                            out_ovf_q    <= ~bus.in_last;
`ifdef PARITY_CHECK_EN
                            out_err_q    <= ~bus.in_last | ((acc_d ^ ODD_BIT) != bus.in_par);
`endif
                            acc_q        <= 1'b0;
                            cnt_q        <= '0;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= ACC;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

endmodule
